// File: rtl/sample_pack_fifo_pkg.sv
// Shared types and constants for the sample packing FIFO.
package sample_pack_fifo_pkg;

  // One stored entry: 32 data bits plus the partial (half) flag.
  localparam int ENTRY_W = 33;

  // Value placed in [31:16] of a partial entry.
  localparam logic [15:0] HALF_PAD = 16'h0000;

  typedef struct packed {
    logic        half;
    logic [31:0] data;
  } entry_t;

  // Full entry: older word in the low half, newer word in the high half.
  function automatic entry_t make_full(input logic [15:0] newer, input logic [15:0] older);
    entry_t e;
    e.half = 1'b0;
    e.data = {newer, older};
    return e;
  endfunction

  // Partial entry carrying a single dangling word.
  function automatic entry_t make_half(input logic [15:0] older);
    entry_t e;
    e.half = 1'b1;
    e.data = {HALF_PAD, older};
    return e;
  endfunction

endpackage

// File: rtl/sample_pack_fifo_if.sv
// Bus bundle between the sampler/host side and the packing FIFO.
interface sample_pack_fifo_if #(
  parameter int DEPTH = 512
);
  localparam int AW = $clog2(DEPTH);

  logic [15:0] in_data;
  logic        in_valid;
  logic        flush;
  logic        clear;
  logic [31:0] out_data;
  logic        out_half;
  logic        out_valid;
  logic        out_ready;
  logic [AW:0] level;
  logic        overflow;

  // Driver side: sampler, control pulses and host reader.
  modport master (
    output in_data, in_valid, flush, clear, out_ready,
    input  out_data, out_half, out_valid, level, overflow
  );

  // The FIFO itself.
  modport slave (
    input  in_data, in_valid, flush, clear, out_ready,
    output out_data, out_half, out_valid, level, overflow
  );
endinterface

// File: rtl/sample_fifo_mem.sv
// DEPTH-entry storage with pointers, level and a lookahead head register.
// The head register is loaded with the entry that will be at the front after
// this edge, so the head is always presented from registered state.
module sample_fifo_mem
  import sample_pack_fifo_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  entry_t                     wr_entry,
  output entry_t                     head,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  entry_t        mem [DEPTH];
  entry_t        head_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic [AW-1:0] rd_addr_next;
  logic          bypass;

  // Address of the entry that will be at the front after this edge.
  always_comb begin
    rd_addr_next = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
    // The new front is being written this very edge (FIFO becomes level 1),
    // so the array still holds stale data there; forward the write instead.
    bypass = push && (wr_ptr_reg == rd_addr_next);
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_entry;
    end
  end

  // Registered lookahead read of the next head entry.
  always_ff @(posedge clk) begin
    head_reg <= bypass ? wr_entry : mem[rd_addr_next];
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + (AW+1)'(1);
        2'b01:   level_reg <= level_reg - (AW+1)'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  assign head  = head_reg;
  assign level = level_reg;
  assign full  = (level_reg == FULL_LEVEL);

endmodule

// File: rtl/sample_pack_fifo.sv
// Packs 16-bit compressed words into 32-bit entries and buffers them in a
// first-word-fall-through FIFO. Drops on full with a sticky overflow flag.
module sample_pack_fifo
  import sample_pack_fifo_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic               clk,
  input  logic               rst_n,
  sample_pack_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic          hold_valid_reg;
  logic          hold_valid_next;
  logic [15:0]   hold_data_reg;
  logic [15:0]   hold_data_next;
  logic          overflow_reg;
  logic          push_req;
  entry_t        push_entry;
  logic          push;
  logic          pop;
  logic          drop;
  logic          full;
  logic          out_valid;
  entry_t        head;
  logic [AW:0]   level;

  // Packing: pair words, then let flush emit whatever is still held.
  always_comb begin
    push_req        = 1'b0;
    push_entry      = '0;
    hold_valid_next = hold_valid_reg;
    hold_data_next  = hold_data_reg;
    if (bus.in_valid) begin
      if (hold_valid_reg) begin
        push_req        = 1'b1;
        push_entry      = make_full(bus.in_data, hold_data_reg);
        hold_valid_next = 1'b0;
      end else begin
        hold_valid_next = 1'b1;
        hold_data_next  = bus.in_data;
      end
    end
    // Flush sees the hold state after input processing, so a word that
    // completed a pair is never flushed a second time.
    if (bus.flush && hold_valid_next) begin
      push_req        = 1'b1;
      push_entry      = make_half(hold_data_next);
      hold_valid_next = 1'b0;
    end
  end

  // Push/pop arbitration; clear overrides everything.
  always_comb begin
    out_valid = (level != '0);
    pop       = out_valid && bus.out_ready && !bus.clear;
    // A full FIFO still accepts when a pop frees a slot on the same edge.
    push      = push_req && !bus.clear && (!full || pop);
    drop      = push_req && !bus.clear && full && !pop;
  end

  // Holding register; packing advances even when the entry is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clear) begin
      hold_valid_reg <= 1'b0;
      hold_data_reg  <= '0;
    end else begin
      hold_valid_reg <= hold_valid_next;
      hold_data_reg  <= hold_data_next;
    end
  end

  // Sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clear) begin
      overflow_reg <= 1'b0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
    end
  end

  sample_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (bus.clear),
    .push     (push),
    .pop      (pop),
    .wr_entry (push_entry),
    .head     (head),
    .level    (level),
    .full     (full)
  );

  assign bus.out_data  = head.data;
  assign bus.out_half  = head.half;
  assign bus.out_valid = out_valid;
  assign bus.level     = level;
  assign bus.overflow  = overflow_reg;

endmodule

// File: tb/tb_sample_pack_fifo.sv
// Self-checking bench: table-driven vectors plus hand sequences, with a
// queue scoreboard of expected entries checked whenever the host pops.
module tb_sample_pack_fifo;
  import sample_pack_fifo_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sample_pack_fifo_if #(.DEPTH(DEPTH)) bus ();

  sample_pack_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Bench-side reference state.
  logic [32:0] sb_q[$];
  logic        m_hv;
  logic [15:0] m_hd;
  logic        m_ovf;

  typedef struct {
    logic        iv;
    logic [15:0] id;
    logic        fl;
    logic        cl;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic        eh;
    int          el;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, update the reference, check after the edge.
  task automatic cycle(input logic iv, input logic [15:0] id, input logic fl,
                       input logic cl, input logic rdy);
    logic [32:0] e;
    logic        req;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.flush     = fl;
    bus.clear     = cl;
    bus.out_ready = rdy;
    #1;
    if (!cl && sb_q.size() > 0 && rdy) begin
      e = sb_q.pop_front();
      chk("pop_data", {31'd0, bus.out_half, bus.out_data}, {31'd0, e});
    end
    if (cl) begin
      sb_q.delete();
      m_hv  = 1'b0;
      m_ovf = 1'b0;
    end else begin
      req = 1'b0;
      e   = '0;
      if (iv) begin
        if (m_hv) begin
          req = 1'b1; e = {1'b0, id, m_hd}; m_hv = 1'b0;
        end else begin
          m_hv = 1'b1; m_hd = id;
        end
      end
      if (fl && m_hv) begin
        req = 1'b1; e = {1'b1, 16'h0000, m_hd}; m_hv = 1'b0;
      end
      if (req) begin
        if (sb_q.size() < DEPTH) sb_q.push_back(e);
        else m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 64'(bus.out_valid), 64'(sb_q.size() > 0));
    chk("level", 64'(bus.level), 64'(sb_q.size()));
    chk("overflow", 64'(bus.overflow), 64'(m_ovf));
    if (bus.out_valid && sb_q.size() > 0)
      chk("head", {31'd0, bus.out_half, bus.out_data}, {31'd0, sb_q[0]});
    $display("cyc iv=%0b id=%h fl=%0b cl=%0b rdy=%0b -> valid=%0b data=%h half=%0b level=%0d ovf=%0b",
             iv, id, fl, cl, rdy, bus.out_valid, bus.out_data, bus.out_half, bus.level, bus.overflow);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.flush = 1'b0;
    bus.clear = 1'b0; bus.out_ready = 1'b0;
    m_hv = 1'b0; m_hd = '0; m_ovf = 1'b0;

    // Basic packing, flush and same-cycle flush vectors.
    tbl[0] = '{1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 0};
    tbl[1] = '{1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2222_1111, 1'b0, 1};
    tbl[2] = '{1'b1, 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2222_1111, 1'b0, 1};
    tbl[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h2222_1111, 1'b0, 2};
    tbl[4] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h2222_1111, 1'b0, 2};
    tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_ABCD, 1'b1, 1};
    tbl[6] = '{1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_ABCD, 1'b1, 1};
    tbl[7] = '{1'b1, 16'h0005, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_ABCD, 1'b1, 2};
    tbl[8] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0005_0004, 1'b0, 1};
    tbl[9] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 0};

    // Reset.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_level", 64'(bus.level), 64'd0);
    chk("reset_overflow", 64'(bus.overflow), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].iv, tbl[i].id, tbl[i].fl, tbl[i].cl, tbl[i].rdy);
      chk($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'(tbl[i].ev));
      chk($sformatf("vec%0d_level", i), 64'(bus.level), 64'(tbl[i].el));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_data", i), 64'(bus.out_data), 64'(tbl[i].ed));
        chk($sformatf("vec%0d_half", i), 64'(bus.out_half), 64'(tbl[i].eh));
      end
    end

    // Overflow: five pairs into a 4-deep FIFO with the reader stalled.
    for (int p = 0; p < 5; p++) begin
      cycle(1'b1, 16'h0100 + 16'(2*p), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 16'h0101 + 16'(2*p), 1'b0, 1'b0, 1'b0);
    end
    chk("ovf_level", 64'(bus.level), 64'd4);
    chk("ovf_flag", 64'(bus.overflow), 64'd1);
    chk("ovf_head", 64'(bus.out_data), 64'h0101_0100);
    // Sixth pair completes on a pop edge: accepted, level unchanged.
    cycle(1'b1, 16'h0200, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0201, 1'b0, 1'b0, 1'b1);
    chk("full_pop_level", 64'(bus.level), 64'd4);
    chk("full_pop_head", 64'(bus.out_data), 64'h0103_0102);

    // Clear while full, overflowed and holding a word.
    cycle(1'b1, 16'h0300, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0301, 1'b0, 1'b1, 1'b1);
    chk("clear_level", 64'(bus.level), 64'd0);
    chk("clear_valid", 64'(bus.out_valid), 64'd0);
    chk("clear_overflow", 64'(bus.overflow), 64'd0);
    cycle(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b0);
    chk("realign_head", 64'(bus.out_data), 64'hBBBB_AAAA);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

    // Streaming with toggling ready: pointers wrap several times.
    for (int k = 0; k < 2*DEPTH+3; k++)
      cycle(1'b1, 16'h1000 + 16'(k), 1'b0, 1'b0, (k % 2) == 0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("stream_tail_half", 64'(sb_q[sb_q.size()-1][32]), 64'd1);
    for (int k = 0; k < 20 && sb_q.size() > 0; k++)
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("drain_valid", 64'(bus.out_valid), 64'd0);

    // Reset mid-operation behaves like clear.
    cycle(1'b1, 16'h7777, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h8888, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb_q.delete(); m_hv = 1'b0; m_ovf = 1'b0;
    chk("rst_mid_level", 64'(bus.level), 64'd0);
    cycle(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_head", 64'(bus.out_data), 64'h0022_0011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
